// File: rtl/computer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | computer : 8-bit SAP-style machine (multi-cycle CPU, 4 KiB ROM at    |
// |            F000-FFFF, 256 B RAM at 0000-00FF) running NOP/HLT/LDI_A. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+

package arch_defs_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 16;

  localparam logic [DATA_WIDTH-1:0] NOP   = 8'h00;
  localparam logic [DATA_WIDTH-1:0] HLT   = 8'h01;
  localparam logic [DATA_WIDTH-1:0] LDI_A = 8'h10;

  localparam logic [ADDR_WIDTH-1:0] ORIGIN = 16'hF000;

  typedef enum logic [2:0] {MS0, MS1, MS2, MS3, MS4, MS5, MS6, MS7} microstep_t;

  // Unknown opcodes execute as one-byte NOPs.
  function automatic logic [1:0] instr_len(input logic [DATA_WIDTH-1:0] op);
    instr_len = (op == LDI_A) ? 2'd2 : 2'd1;
  endfunction
endpackage

module control_unit
  import arch_defs_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] opcode,
  output logic                  load_origin,
  output logic                  load_mar_pc,
  output logic                  mem_read,
  output logic                  oe_ram,
  output logic                  load_ir,
  output logic                  pc_enable,
  output logic                  load_temp_1,
  output logic                  oe_temp_1,
  output logic                  load_a,
  output logic                  load_flags,
  output logic                  load_sets_zn,
  output logic [2:0]            current_microstep
);
  typedef enum logic [2:0] {
    INIT           = 3'd0,
    LATCH_ADDRESS  = 3'd1,
    READ_BYTE      = 3'd2,
    LATCH_BYTE     = 3'd3,
    CHK_MORE_BYTES = 3'd4,
    EXECUTE        = 3'd5,
    HALT           = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  microstep_t microstep_q, microstep_d;
  logic       init_seen_q, init_seen_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      byte_idx_q  <= 2'd0;
      microstep_q <= MS0;
      init_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      microstep_q <= microstep_d;
      init_seen_q <= init_seen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    microstep_d  = microstep_q;
    init_seen_d  = init_seen_q;
    load_origin  = 1'b0;
    load_mar_pc  = 1'b0;
    mem_read     = 1'b0;
    oe_ram       = 1'b0;
    load_ir      = 1'b0;
    pc_enable    = 1'b0;
    load_temp_1  = 1'b0;
    oe_temp_1    = 1'b0;
    load_a       = 1'b0;
    load_flags   = 1'b0;
    load_sets_zn = 1'b0;

    case (state_q)
      INIT: begin
        // INIT spans the first clock after reset release, then fetch begins.
        load_origin = 1'b1;
        init_seen_d = 1'b1;
        if (init_seen_q) state_d = LATCH_ADDRESS;
      end
      LATCH_ADDRESS: begin
        load_mar_pc = 1'b1;
        state_d     = READ_BYTE;
      end
      READ_BYTE: begin
        mem_read = 1'b1;
        state_d  = LATCH_BYTE;
      end
      LATCH_BYTE: begin
        oe_ram      = 1'b1;
        pc_enable   = 1'b1;
        load_ir     = (byte_idx_q == 2'd0);
        load_temp_1 = (byte_idx_q == 2'd1);
        state_d     = CHK_MORE_BYTES;
      end
      CHK_MORE_BYTES: begin
        if (byte_idx_q < instr_len(opcode) - 2'd1) begin
          byte_idx_d = byte_idx_q + 2'd1;
          state_d    = LATCH_ADDRESS;
        end else begin
          byte_idx_d = 2'd0;
          state_d    = EXECUTE;
        end
      end
      EXECUTE: begin
        // Every supported instruction completes in its first microstep.
        microstep_d = MS0;
        state_d     = LATCH_ADDRESS;
        case (opcode)
          LDI_A: begin
            oe_temp_1    = 1'b1;
            load_a       = 1'b1;
            load_flags   = 1'b1;
            load_sets_zn = 1'b1;
          end
          HLT:     state_d = HALT;
          default: state_d = LATCH_ADDRESS;
        endcase
      end
      HALT:    state_d = HALT;
      default: state_d = INIT;
    endcase
  end

  assign current_microstep = microstep_q;
endmodule

module cpu
  import arch_defs_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read
);
  logic load_origin, load_mar_pc, oe_ram, load_ir, pc_enable;
  logic load_temp_1, oe_temp_1, load_a, load_flags, load_sets_zn;
  logic [2:0] current_microstep;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d, temp_1_q, temp_1_d, a_q, a_d;
  logic                  z_q, z_d, n_q, n_d;
  logic [DATA_WIDTH-1:0] bus;

  logic [ADDR_WIDTH-1:0] counter_out;
  logic [DATA_WIDTH-1:0] opcode, a_out, temp_1_out;
  logic                  flag_zero_o, flag_negative_o;

  control_unit u_control_unit (
    .clk               (clk),
    .reset             (reset),
    .opcode            (opcode),
    .load_origin       (load_origin),
    .load_mar_pc       (load_mar_pc),
    .mem_read          (mem_read),
    .oe_ram            (oe_ram),
    .load_ir           (load_ir),
    .pc_enable         (pc_enable),
    .load_temp_1       (load_temp_1),
    .oe_temp_1         (oe_temp_1),
    .load_a            (load_a),
    .load_flags        (load_flags),
    .load_sets_zn      (load_sets_zn),
    .current_microstep (current_microstep)
  );

  always_comb begin
    bus = '0;
    if (oe_ram)         bus = mem_rdata;
    else if (oe_temp_1) bus = temp_1_q;
  end

  always_comb begin
    pc_d     = pc_q;
    mar_d    = mar_q;
    ir_d     = ir_q;
    temp_1_d = temp_1_q;
    a_d      = a_q;
    z_d      = z_q;
    n_d      = n_q;
    if (load_origin)      pc_d = ORIGIN;
    else if (pc_enable)   pc_d = pc_q + 16'd1;
    if (load_mar_pc)      mar_d = pc_q;
    if (load_ir)          ir_d = bus;
    if (load_temp_1)      temp_1_d = bus;
    if (load_a)           a_d = bus;
    if (load_flags && load_sets_zn) begin
      z_d = (bus == '0);
      n_d = bus[DATA_WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      mar_q    <= '0;
      ir_q     <= '0;
      temp_1_q <= '0;
      a_q      <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      mar_q    <= mar_d;
      ir_q     <= ir_d;
      temp_1_q <= temp_1_d;
      a_q      <= a_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

  assign mem_address     = mar_q;
  assign counter_out     = pc_q;
  assign opcode          = ir_q;
  assign a_out           = a_q;
  assign temp_1_out      = temp_1_q;
  assign flag_zero_o     = z_q;
  assign flag_negative_o = n_q;
endmodule

module rom (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en,
  input  logic [11:0] addr,
  output logic [7:0]  rdata
);
  logic [7:0] mem [0:4095];
  logic [7:0] rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

  task automatic init_sim_rom();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  task automatic dump(input logic [11:0] a, output logic [7:0] d);
    d = mem[a];
  endtask
endmodule

// No store instruction exists yet, so the RAM only has a read port.
module ram (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_en,
  input  logic [7:0] addr,
  output logic [7:0] rdata
);
  logic [7:0] mem [0:255];
  logic [7:0] rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

  task automatic init_sim_ram();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask
endmodule

module computer
  import arch_defs_pkg::*;
(
  input logic clk,
  input logic reset
);
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_ROM = 2'd1, SRC_RAM = 2'd2} src_t;

  logic [ADDR_WIDTH-1:0] cpu_mem_address;
  logic                  cpu_mem_read;
  logic [DATA_WIDTH-1:0] cpu_mem_rdata, rom_rdata, ram_rdata;
  logic                  rom_sel, ram_sel;
  src_t                  src_q, src_d;

  assign rom_sel = (cpu_mem_address[15:12] == 4'hF);
  assign ram_sel = (cpu_mem_address[15:8] == 8'h00);

  cpu u_cpu (
    .clk         (clk),
    .reset       (reset),
    .mem_rdata   (cpu_mem_rdata),
    .mem_address (cpu_mem_address),
    .mem_read    (cpu_mem_read)
  );

  rom u_rom (
    .clk   (clk),
    .reset (reset),
    .rd_en (cpu_mem_read && rom_sel),
    .addr  (cpu_mem_address[11:0]),
    .rdata (rom_rdata)
  );

  ram u_ram (
    .clk   (clk),
    .reset (reset),
    .rd_en (cpu_mem_read && ram_sel),
    .addr  (cpu_mem_address[7:0]),
    .rdata (ram_rdata)
  );

  // The source is registered alongside the synchronous read so the mux lines up with the data.
  always_comb begin
    src_d = src_q;
    if (cpu_mem_read) begin
      if (rom_sel)      src_d = SRC_ROM;
      else if (ram_sel) src_d = SRC_RAM;
      else              src_d = SRC_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) src_q <= SRC_NONE;
    else        src_q <= src_d;
  end

  always_comb begin
    cpu_mem_rdata = '0;
    case (src_q)
      SRC_ROM: cpu_mem_rdata = rom_rdata;
      SRC_RAM: cpu_mem_rdata = ram_rdata;
      default: cpu_mem_rdata = '0;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_computer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_computer : self-checking bench for computer (directed + random).  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_computer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  computer dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds reset low for two cycles with a program loaded; returns at a falling edge.
  task automatic reset_and_load(input logic [7:0] img[$]);
    @(negedge clk);
    reset = 1'b0;
    dut.u_rom.init_sim_rom();
    dut.u_ram.init_sim_ram();
    foreach (img[i]) dut.u_rom.mem[i] = img[i];
    step(2);
  endtask

  logic [7:0] img[$];
  logic [7:0] op, imm, exp_a, dumped;
  logic       exp_z, exp_n, done;
  int         addr;

  initial begin
    // ---------------- reset state ----------------
    img = '{8'h10, 8'hF5, 8'h01};
    reset_and_load(img);
    check("rst_pc",     dut.u_cpu.counter_out, 32'h0);
    check("rst_mar",    dut.cpu_mem_address, 32'h0);
    check("rst_ir",     dut.u_cpu.opcode, 32'h0);
    check("rst_a",      dut.u_cpu.a_out, 32'h0);
    check("rst_temp",   dut.u_cpu.temp_1_out, 32'h0);
    check("rst_zn",     {dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o}, 32'h0);
    check("rst_origin", dut.u_cpu.load_origin, 32'h1);
    check("rst_ctl",    {dut.u_cpu.load_mar_pc, dut.cpu_mem_read, dut.u_cpu.oe_ram, dut.u_cpu.load_ir,
                         dut.u_cpu.pc_enable, dut.u_cpu.load_a}, 32'h0);
    check("rst_ms",     dut.u_cpu.u_control_unit.current_microstep, 32'h0);
    dut.u_rom.dump(12'h001, dumped);
    check("rom_dump",   dumped, 32'hF5);

    // ---------------- directed LDI_A F5 ; HLT ----------------
    reset = 1'b1;
    step(1);
    check("init_origin", dut.u_cpu.load_origin, 32'h1);
    check("init_no_mar", dut.u_cpu.load_mar_pc, 32'h0);
    step(1);
    check("la0_pc",  dut.u_cpu.counter_out, 32'hF000);
    check("la0_mar", dut.u_cpu.load_mar_pc, 32'h1);
    step(1);
    check("rb0_rd",   dut.cpu_mem_read, 32'h1);
    check("rb0_addr", dut.cpu_mem_address, 32'hF000);
    step(1);
    check("lb0_ctl", {dut.u_cpu.oe_ram, dut.u_cpu.load_ir, dut.u_cpu.pc_enable, dut.u_cpu.load_temp_1}, 32'hE);
    step(1);
    check("chk0_op", dut.u_cpu.opcode, 32'h10);
    check("chk0_cu_op", dut.u_cpu.u_control_unit.opcode, 32'h10);
    step(1);
    check("la1_pc", dut.u_cpu.counter_out, 32'hF001);
    step(1);
    check("rb1_addr", dut.cpu_mem_address, 32'hF001);
    step(1);
    check("lb1_ctl", {dut.u_cpu.load_temp_1, dut.u_cpu.load_ir}, 32'h2);
    step(1);
    check("chk1_temp", dut.u_cpu.temp_1_out, 32'hF5);
    check("chk1_op",   dut.u_cpu.opcode, 32'h10);
    step(1);
    check("exe_ms",  dut.u_cpu.u_control_unit.current_microstep, 32'h0);
    check("exe_ctl", {dut.u_cpu.oe_temp_1, dut.u_cpu.load_a, dut.u_cpu.load_flags, dut.u_cpu.load_sets_zn}, 32'hF);
    step(1);
    check("post_a",  dut.u_cpu.a_out, 32'hF5);
    check("post_zn", {dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o}, 32'h1);
    step(5);
    check("hlt_op", dut.u_cpu.opcode, 32'h01);
    check("hlt_pc", dut.u_cpu.counter_out, 32'hF003);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("hold_op", dut.u_cpu.opcode, 32'h01);
      check("hold_pc", dut.u_cpu.counter_out, 32'hF003);
    end

    // ---------------- LDI_A 00 sets Z ----------------
    img = '{8'h10, 8'h00, 8'h01};
    reset_and_load(img);
    reset = 1'b1;
    step(11);
    check("zero_a",  dut.u_cpu.a_out, 32'h00);
    check("zero_zn", {dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o}, 32'h2);

    // ---------------- reset in READ_BYTE of F001 ----------------
    img = '{8'h10, 8'hF5, 8'h01};
    reset_and_load(img);
    reset = 1'b1;
    step(7);
    check("mid_pre_addr", dut.cpu_mem_address, 32'hF001);
    #2 reset = 1'b0;
    #1;
    check("mid_pc",     dut.u_cpu.counter_out, 32'h0);
    check("mid_mar",    dut.cpu_mem_address, 32'h0);
    check("mid_rd",     dut.cpu_mem_read, 32'h0);
    check("mid_ir",     dut.u_cpu.opcode, 32'h0);
    check("mid_origin", dut.u_cpu.load_origin, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    step(2);
    check("mid_restart_pc", dut.u_cpu.counter_out, 32'hF000);

    // ---------------- random programs vs. instruction-level model ----------------
    for (int p = 0; p < 8; p++) begin
      img.delete();
      for (int i = 0; i < int'($urandom_range(3, 10)); i++) begin
        case ($urandom_range(0, 3))
          0, 1: begin
            imm = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            img.push_back(8'h10);
            img.push_back(imm);
          end
          2: img.push_back(8'h00);
          default: begin
            op = 8'($urandom_range(2, 255));
            if (op == 8'h10) op = 8'h11;
            img.push_back(op);
          end
        endcase
      end
      img.push_back(8'h01);

      reset_and_load(img);
      reset = 1'b1;
      step(2);
      exp_a = 8'h00;
      exp_z = 1'b0;
      exp_n = 1'b0;
      addr  = 0;
      done  = 1'b0;
      while (!done && addr < img.size()) begin
        check("rnd_pc", dut.u_cpu.counter_out, 32'hF000 + addr);
        op = img[addr];
        if (op == 8'h01) begin
          step(5);
          check("rnd_hlt_op", dut.u_cpu.opcode, 32'h01);
          step(4);
          check("rnd_hlt_pc", dut.u_cpu.counter_out, 32'hF000 + addr + 1);
          done = 1'b1;
        end else begin
          if (op == 8'h10) begin
            exp_a = img[addr+1];
            exp_z = (exp_a == 8'h00);
            exp_n = exp_a[7];
            addr  = addr + 2;
            step(9);
          end else begin
            addr = addr + 1;
            step(5);
          end
          check("rnd_a",  dut.u_cpu.a_out, {24'h0, exp_a});
          check("rnd_zn", {dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o}, {30'h0, exp_z, exp_n});
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/computer.md
# computer

Top-level 8-bit SAP-style computer. It contains a multi-cycle CPU (`u_cpu`, with control unit `u_control_unit`), a 4 KiB program ROM (`u_rom`) mapped at F000–FFFF, and a 256-byte RAM (`u_ram`) mapped at 0000–00FF. After reset it fetches and executes byte-coded instructions from F000 through a fixed fetch state machine. Supported instructions: NOP, HLT and LDI_A.

## Interface
- Parameters: none. Widths come from `arch_defs_pkg`: DATA_WIDTH = 8, ADDR_WIDTH = 16.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state.

Required hierarchical names, used by benches:
- `cpu_mem_address[15:0]`, `cpu_mem_read`
- In `u_cpu`: `counter_out[15:0]`, `opcode`, `a_out`, `temp_1_out`, `flag_zero_o`, `flag_negative_o`
- Control lines in `u_cpu`: `load_origin`, `load_mar_pc`, `oe_ram`, `load_ir`, `pc_enable`, `load_temp_1`, `oe_temp_1`, `load_a`, `load_flags`, `load_sets_zn`
- In `u_control_unit`: `current_microstep`, `opcode`
- ROM: `u_rom.mem[0:4095]`; RAM: `u_ram.mem[0:255]`
- Simulation tasks: `u_ram.init_sim_ram`, `u_rom.init_sim_rom` (zero the memory) and `u_rom.dump`.

## Operation
Opcodes (defined in `arch_defs_pkg`):
- NOP = 8'h00, 1 byte.
- HLT = 8'h01, 1 byte.
- LDI_A = 8'h10, 2 bytes: opcode, then immediate.
- Any other value executes as a 1-byte NOP.

Control-unit states: INIT, LATCH_ADDRESS, READ_BYTE, LATCH_BYTE, CHK_MORE_BYTES, EXECUTE, HALT.
- All control lines are Moore outputs of the current state.
- Every control line is 0 unless listed for the state below.
- INIT: `load_origin` = 1, so PC <= 16'hF000. Next state: LATCH_ADDRESS.
- LATCH_ADDRESS: `load_mar_pc` = 1, so MAR <= PC. Next state: READ_BYTE.
- READ_BYTE: `cpu_mem_read` = 1 with `cpu_mem_address` = MAR. Memory reads are synchronous, so data is valid in the next cycle. Next state: LATCH_BYTE.
- LATCH_BYTE: `oe_ram` = 1 (memory data drives the internal bus) and `pc_enable` = 1 (PC += 1).
  - Byte 0: `load_ir` = 1, IR <= bus.
  - Byte 1: `load_temp_1` = 1, temp_1 <= bus.
  - Next state: CHK_MORE_BYTES.
- CHK_MORE_BYTES: if the byte index is below the instruction length − 1, increment the index and go to LATCH_ADDRESS. Otherwise clear the index and go to EXECUTE.
- EXECUTE: `current_microstep` = MS0. Behaviour per opcode:
  - LDI_A: `oe_temp_1`, `load_a`, `load_flags` and `load_sets_zn` = 1. A <= temp_1; Z <= (temp_1 == 0); N <= temp_1[7]. Next state: LATCH_ADDRESS.
  - NOP: next state LATCH_ADDRESS.
  - HLT: next state HALT.
- HALT: all control lines 0. The PC is frozen and the state is held until reset.
- Address decode:
  - F000–FFFF selects the ROM (index = address[11:0]).
  - 0000–00FF selects the RAM.
  - All other addresses read 8'h00.
- PC arithmetic is 16-bit and wraps FFFF -> 0000.

## Timing
- Reset values:
  - PC, MAR, IR, temp_1, A = 0
  - Z and N = 0
  - byte index = 0, microstep = MS0, state = INIT
  - all control lines 0, except `load_origin`, which is 1 in INIT.
- The first rising edge after reset deasserts leaves the state in INIT. The next edge enters LATCH_ADDRESS.
- Fetch costs 4 cycles per byte. Each instruction costs 4 × length + 1 cycles.
  - LDI_A: 9 cycles. A and the flags are visible in the cycle after EXECUTE.
- Asserting reset at any point immediately forces all reset values; fetch then restarts at INIT.
- IR holds its value through operand fetch, so `opcode` stays stable until the next opcode byte is latched.

## Test plan
- Reset then run with the ROM program F000=10, F001=F5, F002=01 (each line below is one cycle after the previous):
  - INIT: `load_origin` = 1.
  - LATCH_ADDRESS: `counter_out` = F000, `load_mar_pc` = 1.
  - READ_BYTE: `cpu_mem_read` = 1, `cpu_mem_address` = F000.
  - LATCH_BYTE: `oe_ram`, `load_ir` and `pc_enable` = 1.
  - CHK_MORE_BYTES: `opcode` = LDI_A.
- Operand fetch for the same program:
  - LATCH_ADDRESS: `counter_out` = F001.
  - READ_BYTE: `cpu_mem_address` = F001.
  - LATCH_BYTE: `load_temp_1` = 1.
  - CHK_MORE_BYTES: `temp_1_out` = F5.
- Execute for the same program:
  - EXECUTE cycle: `current_microstep` = MS0; `oe_temp_1`, `load_a`, `load_flags` and `load_sets_zn` = 1.
  - Next cycle: A = F5, Z = 0, N = 1.
- HLT at F002: after a further 5 cycles, `opcode` = HLT and `counter_out` = F003. Both remain stable for 20 more cycles.
- LDI_A with immediate 00: A = 00, Z = 1, N = 0.
- Reset asserted mid-fetch (during READ_BYTE of F001): all outputs return to reset values at once; after release, `counter_out` = F000 again.
